// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-back, write-allocate data cache for the
// MEM stage. Owns tag/valid/dirty/data arrays and sequences victim write-back
// and line refill with off-chip memory, freezing the pipeline via stall_o.
// Ports:
//   clk_i, rst_i (async, active-low)
//   cpu_read_i/cpu_write_i/cpu_addr_i/cpu_wdata_i : EX/MEM request
//   cpu_rdata_o : load data, stall_o : pipeline freeze
//   mem_enable_o/mem_write_o/mem_addr_o/mem_wdata_o : memory request
//   mem_rdata_i/mem_ack_i : memory response (ack is a one-cycle pulse)
module dcache_ctrl #(
  parameter int unsigned SETS   = 32,
  parameter int unsigned LINE_W = 256,
  parameter int unsigned TAG_W  = 22
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_read_i,
  input  logic              cpu_write_i,
  input  logic [31:0]       cpu_addr_i,
  input  logic [31:0]       cpu_wdata_i,
  output logic [31:0]       cpu_rdata_o,
  output logic              stall_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [31:0]       mem_addr_o,
  output logic [LINE_W-1:0] mem_wdata_o,
  input  logic [LINE_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i
);

  localparam int unsigned INDEX_W  = $clog2(SETS);
  localparam int unsigned OFFSET_W = $clog2(LINE_W / 8);
  localparam int unsigned WORD_W   = OFFSET_W - 2;

  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_e;

  state_e state_q, state_d;

  logic [SETS-1:0]    valid_q, valid_d, dirty_q, dirty_d;
  logic [TAG_W-1:0]   tag_q  [SETS];
  logic [LINE_W-1:0]  data_q [SETS];

  // Request latched on a miss; used exclusively until the return to IDLE.
  logic [TAG_W-1:0]   ltag_q, ltag_d;
  logic [INDEX_W-1:0] lidx_q, lidx_d;
  logic [WORD_W-1:0]  lword_q, lword_d;
  logic [31:0]        lwdata_q, lwdata_d;
  logic               lwrite_q, lwrite_d;

  logic               data_we, tag_we;
  logic [INDEX_W-1:0] wr_idx;
  logic [LINE_W-1:0]  wr_line;

  logic [TAG_W-1:0]   tag_in;
  logic [INDEX_W-1:0] idx_in;
  logic [WORD_W-1:0]  word_in;
  logic [LINE_W-1:0]  hit_line;
  logic               req, hit;
  logic               unused_addr_bits;

  assign tag_in           = cpu_addr_i[31 -: TAG_W];
  assign idx_in           = cpu_addr_i[OFFSET_W +: INDEX_W];
  assign word_in          = cpu_addr_i[2 +: WORD_W];
  assign unused_addr_bits = ^cpu_addr_i[1:0];
  assign req              = cpu_read_i | cpu_write_i;
  assign hit              = valid_q[idx_in] && (tag_q[idx_in] == tag_in);
  assign hit_line         = data_q[idx_in];

  function automatic logic [LINE_W-1:0] merge_word(input logic [LINE_W-1:0] line,
                                                   input logic [WORD_W-1:0] w,
                                                   input logic [31:0]       d);
    merge_word = line;
    merge_word[{w, 5'b0} +: 32] = d;
  endfunction

  // State register plus control/status flops.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= IDLE;
      valid_q  <= '0;
      dirty_q  <= '0;
      ltag_q   <= '0;
      lidx_q   <= '0;
      lword_q  <= '0;
      lwdata_q <= '0;
      lwrite_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      dirty_q  <= dirty_d;
      ltag_q   <= ltag_d;
      lidx_q   <= lidx_d;
      lword_q  <= lword_d;
      lwdata_q <= lwdata_d;
      lwrite_q <= lwrite_d;
    end
  end

  // Tag and data arrays keep their contents across reset.
  always_ff @(posedge clk_i) begin
    if (data_we) data_q[wr_idx] <= wr_line;
    if (tag_we)  tag_q[wr_idx]  <= ltag_q;
  end

  // Next-state and array-update logic.
  always_comb begin
    state_d  = state_q;
    valid_d  = valid_q;
    dirty_d  = dirty_q;
    ltag_d   = ltag_q;
    lidx_d   = lidx_q;
    lword_d  = lword_q;
    lwdata_d = lwdata_q;
    lwrite_d = lwrite_q;
    data_we  = 1'b0;
    tag_we   = 1'b0;
    wr_idx   = idx_in;
    wr_line  = '0;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (hit) begin
            if (cpu_write_i) begin
              data_we         = 1'b1;
              wr_line         = merge_word(hit_line, word_in, cpu_wdata_i);
              dirty_d[idx_in] = 1'b1;
            end
          end else begin
            ltag_d   = tag_in;
            lidx_d   = idx_in;
            lword_d  = word_in;
            lwdata_d = cpu_wdata_i;
            lwrite_d = cpu_write_i;
            state_d  = (valid_q[idx_in] && dirty_q[idx_in]) ? WRITEBACK : ALLOCATE;
          end
        end
      end
      WRITEBACK: begin
        if (mem_ack_i) state_d = ALLOCATE;
      end
      ALLOCATE: begin
        if (mem_ack_i) begin
          data_we         = 1'b1;
          tag_we          = 1'b1;
          wr_idx          = lidx_q;
          // A pending store is merged into the refill so the line lands dirty
          // in a single array write.
          wr_line         = lwrite_q ? merge_word(mem_rdata_i, lword_q, lwdata_q)
                                     : mem_rdata_i;
          valid_d[lidx_q] = 1'b1;
          dirty_d[lidx_q] = lwrite_q;
          state_d         = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs.
  always_comb begin
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = '0;
    mem_wdata_o  = '0;
    cpu_rdata_o  = '0;
    // Reset overrides the combinational miss term so stall drops immediately.
    stall_o      = rst_i && ((state_q != IDLE) || (req && !hit));
    case (state_q)
      IDLE: begin
        if (rst_i && cpu_read_i && !cpu_write_i && hit)
          cpu_rdata_o = hit_line[{word_in, 5'b0} +: 32];
      end
      WRITEBACK: begin
        mem_enable_o = 1'b1;
        mem_write_o  = 1'b1;
        mem_addr_o   = {tag_q[lidx_q], lidx_q, {OFFSET_W{1'b0}}};
        mem_wdata_o  = data_q[lidx_q];
      end
      ALLOCATE: begin
        mem_enable_o = 1'b1;
        mem_addr_o   = {ltag_q, lidx_q, {OFFSET_W{1'b0}}};
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
module tb_dcache_ctrl;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         rd = 1'b0, wr = 1'b0;
  logic [31:0]  addr = '0, wdata = '0;
  logic [31:0]  cpu_rdata;
  logic         stall_o, mem_enable_o, mem_write_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_wdata_o;
  logic [255:0] mrdata = '0;
  logic         mack = 1'b0;

  int checks = 0;
  int failures = 0;
  int stall_cnt = 0;

  dcache_ctrl #(.SETS(32), .LINE_W(256), .TAG_W(22)) dut (
    .clk_i(clk), .rst_i(rst_n),
    .cpu_read_i(rd), .cpu_write_i(wr), .cpu_addr_i(addr), .cpu_wdata_i(wdata),
    .cpu_rdata_o(cpu_rdata), .stall_o(stall_o),
    .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mrdata), .mem_ack_i(mack)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (stall_o) stall_cnt++;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chk_rdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[8];

  logic [255:0] line_a, line_b, line_c, line_d, exp_line;

  function automatic logic [255:0] make_line(input logic [31:0] base);
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[k*32 +: 32] = base + 32'(k);
    return l;
  endfunction

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk256(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    rd = r; wr = w; addr = a; wdata = d;
    #1;
  endtask

  // Memory model: wait (bounded) for a request, check it, hold for `delay`
  // cycles, then pulse ack with the refill line.
  task automatic serve(input string name, input logic exp_write, input logic [31:0] exp_addr,
                       input logic chk_wdata, input logic [255:0] exp_wdata,
                       input logic [255:0] rline, input int unsigned delay);
    int unsigned n = 0;
    while (!mem_enable_o && n < 50) begin
      step();
      n++;
    end
    chk1({name, " enable"}, mem_enable_o, 1'b1);
    chk1({name, " write"}, mem_write_o, exp_write);
    chk32({name, " addr"}, mem_addr_o, exp_addr);
    if (chk_wdata) chk256({name, " wdata"}, mem_wdata_o, exp_wdata);
    repeat (delay) step();
    chk1({name, " stall held"}, stall_o, 1'b1);
    chk32({name, " addr held"}, mem_addr_o, exp_addr);
    mrdata = rline;
    mack = 1'b1;
    step();
    mack = 1'b0;
  endtask

  initial begin
    line_a = make_line(32'hA000_0000);
    line_a[31:0]  = 32'h0000_0000;
    line_a[63:32] = 32'hDEAD_BEEF;
    line_b = make_line(32'hB000_0000);
    line_c = make_line(32'hC000_0000);
    line_d = make_line(32'hD000_0000);

    vecs[0] = '{1'b0, 1'b0, 32'h40, 32'h0,         1'b1, 32'h0};
    vecs[1] = '{1'b1, 1'b0, 32'h40, 32'h0,         1'b1, 32'h0};
    vecs[2] = '{1'b1, 1'b0, 32'h44, 32'h0,         1'b1, 32'hDEAD_BEEF};
    vecs[3] = '{1'b1, 1'b0, 32'h5C, 32'h0,         1'b1, 32'hA000_0007};
    vecs[4] = '{1'b0, 1'b1, 32'h4C, 32'hA5A5_A5A5, 1'b0, 32'h0};
    vecs[5] = '{1'b1, 1'b0, 32'h4C, 32'h0,         1'b1, 32'hA5A5_A5A5};
    vecs[6] = '{1'b1, 1'b0, 32'h47, 32'h0,         1'b1, 32'hDEAD_BEEF};
    vecs[7] = '{1'b1, 1'b0, 32'h50, 32'h0,         1'b1, 32'hA000_0004};

    // Reset state, including a request presented while in reset.
    drive(1'b1, 1'b0, 32'h40, 32'h0);
    #10;
    chk1("rst stall", stall_o, 1'b0);
    chk1("rst mem_en", mem_enable_o, 1'b0);
    chk1("rst mem_write", mem_write_o, 1'b0);
    chk32("rst mem_addr", mem_addr_o, 32'h0);
    chk256("rst mem_wdata", mem_wdata_o, 256'h0);
    chk32("rst rdata", cpu_rdata, 32'h0);
    step();
    rst_n = 1'b1;

    // Cold load miss: stall in the same cycle, refill after 3 cycles.
    drive(1'b1, 1'b0, 32'h40, 32'h0);
    chk1("miss40 stall now", stall_o, 1'b1);
    chk1("miss40 no mem yet", mem_enable_o, 1'b0);
    serve("alloc40", 1'b0, 32'h40, 1'b0, '0, line_a, 3);
    drive(1'b1, 1'b0, 32'h44, 32'h0);
    chk1("after refill stall", stall_o, 1'b0);
    chk32("after refill rdata", cpu_rdata, 32'hDEAD_BEEF);
    step();

    // Ack while idle is ignored.
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    mrdata = '1;
    mack = 1'b1;
    step();
    mack = 1'b0;
    chk1("idle ack mem_en", mem_enable_o, 1'b0);

    // Hit vectors on the resident line.
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
      chk1($sformatf("vec%0d stall", i), stall_o, 1'b0);
      chk1($sformatf("vec%0d mem_en", i), mem_enable_o, 1'b0);
      if (vecs[i].chk_rdata) chk32($sformatf("vec%0d rdata", i), cpu_rdata, vecs[i].exp_rdata);
      step();
    end

    // Dirty eviction: write-back then refill.
    drive(1'b0, 1'b1, 32'h48, 32'hCAFE_F00D);
    chk1("store48 stall", stall_o, 1'b0);
    step();
    exp_line = line_a;
    exp_line[95:64]  = 32'hCAFE_F00D;
    exp_line[127:96] = 32'hA5A5_A5A5;
    stall_cnt = 0;
    drive(1'b1, 1'b0, 32'h448, 32'h0);
    chk1("miss448 stall now", stall_o, 1'b1);
    serve("wb40", 1'b1, 32'h40, 1'b1, exp_line, '0, 2);
    serve("alloc440", 1'b0, 32'h440, 1'b0, '0, line_b, 2);
    drive(1'b1, 1'b0, 32'h448, 32'h0);
    chk1("after 448 stall", stall_o, 1'b0);
    chk32("after 448 rdata", cpu_rdata, 32'hB000_0002);
    @(negedge clk);
    #1;
    chk32("evict stall cycles", 32'(stall_cnt), 32'd7);
    step();

    // Store miss to a clean line: allocate only, merged line is dirty.
    drive(1'b0, 1'b1, 32'h100, 32'h1234_5678);
    chk1("miss100 stall now", stall_o, 1'b1);
    serve("alloc100", 1'b0, 32'h100, 1'b0, '0, line_c, 1);
    drive(1'b0, 1'b1, 32'h100, 32'h1234_5678);
    chk1("store100 rehit stall", stall_o, 1'b0);
    step();
    drive(1'b1, 1'b0, 32'h100, 32'h0);
    chk32("load100 rdata", cpu_rdata, 32'h1234_5678);
    step();
    exp_line = line_c;
    exp_line[31:0] = 32'h1234_5678;
    drive(1'b1, 1'b0, 32'h500, 32'h0);
    serve("wb100", 1'b1, 32'h100, 1'b1, exp_line, '0, 0);
    serve("alloc500", 1'b0, 32'h500, 1'b0, '0, line_d, 0);
    drive(1'b1, 1'b0, 32'h500, 32'h0);
    chk32("load500 rdata", cpu_rdata, 32'hD000_0000);
    step();

    // Reset in the middle of an allocate.
    drive(1'b1, 1'b0, 32'h840, 32'h0);
    step();
    chk1("alloc840 mem_en", mem_enable_o, 1'b1);
    chk32("alloc840 addr", mem_addr_o, 32'h840);
    rst_n = 1'b0;
    #1;
    chk1("midrst mem_en", mem_enable_o, 1'b0);
    chk1("midrst stall", stall_o, 1'b0);
    chk32("midrst mem_addr", mem_addr_o, 32'h0);
    step();
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    mrdata = '1;
    mack = 1'b1;
    step();
    mack = 1'b0;
    chk1("late ack mem_en", mem_enable_o, 1'b0);
    chk1("late ack stall", stall_o, 1'b0);
    drive(1'b1, 1'b0, 32'h40, 32'h0);
    chk1("post-rst 40 miss", stall_o, 1'b1);
    serve("alloc40b", 1'b0, 32'h40, 1'b0, '0, line_a, 1);
    drive(1'b1, 1'b0, 32'h40, 32'h0);
    chk32("post-rst 40 rdata", cpu_rdata, 32'h0);
    step();

    // Read and write together on a hit: behaves as a store.
    drive(1'b1, 1'b1, 32'h40, 32'h1);
    chk1("rdwr stall", stall_o, 1'b0);
    chk1("rdwr mem_en", mem_enable_o, 1'b0);
    step();
    drive(1'b1, 1'b0, 32'h40, 32'h0);
    chk32("rdwr word0", cpu_rdata, 32'h1);
    step();
    exp_line = line_a;
    exp_line[31:0] = 32'h1;
    drive(1'b1, 1'b0, 32'h440, 32'h0);
    serve("wb40b", 1'b1, 32'h40, 1'b1, exp_line, '0, 0);
    serve("alloc440b", 1'b0, 32'h440, 1'b0, '0, line_b, 0);
    drive(1'b1, 1'b0, 32'h440, 32'h0);
    chk32("load440 rdata", cpu_rdata, 32'hB000_0000);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
